pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - interlock, stall and data-memory wait control for an in-order pipeline
//
// Tracks the destination of every instruction still in flight (EX, MEM, WB)
// and stalls decode on a read-after-write dependency, since the datapath has
// no forwarding. A load/store sitting in MEM freezes the whole pipe until the
// data memory acknowledges; a missing acknowledge for too long locks the block
// in an error state until reset.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   id_valid     decode holds a valid instruction
//   id_rs1/2     source register addresses, id_rs1_re/id_rs2_re their read enables
//   id_rd        destination register, id_rd_we its write enable
//   id_is_mem    decoded instruction is a load or store
//   id_br        branch taken, resolved in decode
//   mem_ack      data memory completes the current access
//   pc_we        PC load enable
//   ifid_we      IF/ID load enable
//   ifid_flush   clear IF/ID to a NOP
//   idex_bubble  load a NOP into ID/EX
//   pipe_adv     ID/EX, EX/MEM and MEM/WB advance
//   mem_req      data memory access request
//   err          sticky memory-timeout flag
//   stall_cnt    saturating count of hazard-stall cycles

module pipe_hazard_ctrl #(
    parameter int TIMEOUT     = 255,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_rs1_re,
    input  logic                   id_rs2_re,
    input  logic [4:0]             id_rd,
    input  logic                   id_rd_we,
    input  logic                   id_is_mem,
    input  logic                   id_br,
    input  logic                   mem_ack,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   pipe_adv,
    output logic                   mem_req,
    output logic                   err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_mem;
    } slot_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    state_t     state;
    logic [7:0] wait_cnt;
    logic       err_q;

    slot_t      ex_q;
    slot_t      mem_q;
    // WB only matters for hazard detection, so it does not carry is_mem.
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_we;

    logic       mem_op;
    logic       hazard;
    logic       freeze;
    logic       issue;
    logic       req_int;
    logic       bubble_int;

    // One source operand against one in-flight writer; x0 is never a dependency.
    function automatic logic raw_hit(
        input logic       re,
        input logic [4:0] rs,
        input logic       valid,
        input logic       we,
        input logic [4:0] rd
    );
        return re && (rs != 5'd0) && valid && we && (rd == rs);
    endfunction

    assign mem_op = mem_q.valid && mem_q.is_mem;

    always_comb begin
        hazard = 1'b0;
        if (id_valid) begin
            hazard = raw_hit(id_rs1_re, id_rs1, ex_q.valid,  ex_q.we,  ex_q.rd)
                  || raw_hit(id_rs1_re, id_rs1, mem_q.valid, mem_q.we, mem_q.rd)
                  || raw_hit(id_rs1_re, id_rs1, wb_valid,    wb_we,    wb_rd)
                  || raw_hit(id_rs2_re, id_rs2, ex_q.valid,  ex_q.we,  ex_q.rd)
                  || raw_hit(id_rs2_re, id_rs2, mem_q.valid, mem_q.we, mem_q.rd)
                  || raw_hit(id_rs2_re, id_rs2, wb_valid,    wb_we,    wb_rd);
        end
    end

    // An un-acknowledged access in MEM holds every stage, including the cycle
    // the request is first raised from IDLE.
    always_comb begin
        freeze  = 1'b1;
        req_int = 1'b0;
        case (state)
            IDLE: begin
                freeze  = mem_op && !mem_ack;
                req_int = mem_op;
            end
            MEM_WAIT: begin
                freeze  = !mem_ack;
                req_int = 1'b1;
            end
            default: begin
                freeze  = 1'b1;
                req_int = 1'b0;
            end
        endcase
    end

    // Freeze dominates a hazard: no bubble is inserted while everything is held.
    assign issue      = id_valid && !hazard && !freeze;
    assign bubble_int = hazard && !freeze;

    // Reset gating keeps every enable low while reset is held, independent of
    // whatever the cleared state would otherwise imply.
    assign pipe_adv    = reset && !freeze;
    assign pc_we       = reset && !freeze && !hazard;
    assign ifid_we     = reset && !freeze && !hazard;
    assign idex_bubble = reset && bubble_int;
    // A branch stalled on a hazard is not flushed; it re-resolves once issued.
    assign ifid_flush  = reset && issue && id_br;
    assign mem_req     = reset && req_int;
    assign err         = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && !mem_ack) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    // ERR (and any unused encoding) is terminal until reset.
                    state <= ERR;
                    err_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_we    <= 1'b0;
        end else if (!freeze) begin
            if (issue) begin
                ex_q <= '{valid: 1'b1, rd: id_rd, we: id_rd_we, is_mem: id_is_mem};
            end else begin
                ex_q <= '0;
            end
            mem_q    <= ex_q;
            wb_valid <= mem_q.valid;
            wb_rd    <= mem_q.rd;
            wb_we    <= mem_q.we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (bubble_int && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl, two parameter sets on shared stimulus

module tb_pipe_hazard_ctrl;

    localparam int TO_A = 255;
    localparam int SW_A = 16;
    localparam int TO_B = 3;
    localparam int SW_B = 4;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_re;
    logic       id_rs2_re;
    logic [4:0] id_rd;
    logic       id_rd_we;
    logic       id_is_mem;
    logic       id_br;
    logic       mem_ack;

    logic pc_we_a, ifid_we_a, flush_a, bubble_a, adv_a, req_a, err_a;
    logic pc_we_b, ifid_we_b, flush_b, bubble_b, adv_b, req_b, err_b;
    logic [SW_A-1:0] stall_a;
    logic [SW_B-1:0] stall_b;

    pipe_hazard_ctrl #(.TIMEOUT(TO_A), .STALL_CNT_W(SW_A)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_mem(id_is_mem), .id_br(id_br),
        .mem_ack(mem_ack), .pc_we(pc_we_a), .ifid_we(ifid_we_a), .ifid_flush(flush_a),
        .idex_bubble(bubble_a), .pipe_adv(adv_a), .mem_req(req_a), .err(err_a),
        .stall_cnt(stall_a)
    );

    pipe_hazard_ctrl #(.TIMEOUT(TO_B), .STALL_CNT_W(SW_B)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_mem(id_is_mem), .id_br(id_br),
        .mem_ack(mem_ack), .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(flush_b),
        .idex_bubble(bubble_b), .pipe_adv(adv_b), .mem_req(req_b), .err(err_b),
        .stall_cnt(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rst_n; int v; int rs1; int rs2; int re1; int re2;
        int rd; int we; int m; int br; int ack;
    } stim_t;

    typedef struct { int v; int rd; int we; int m; } mslot_t;

    // Behavioural view: the three in-flight instructions, how many cycles the
    // access in MEM has gone unanswered, the error latch and the stall total.
    typedef struct {
        mslot_t ex; mslot_t mem; mslot_t wb;
        int reqs; int err; int stalls;
    } mstate_t;

    typedef struct {
        int pc_we; int ifid_we; int flush; int bubble; int adv; int req; int err; int stall;
    } exp_t;

    typedef struct { exp_t a; exp_t b; } exp_pair_t;

    exp_pair_t sb[$];
    mstate_t   ma;
    mstate_t   mb;
    int        n_checks = 0;
    int        n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic mstate_t empty_state();
        mstate_t s;
        s.ex = '{default: 0}; s.mem = '{default: 0}; s.wb = '{default: 0};
        s.reqs = 0; s.err = 0; s.stalls = 0;
        return s;
    endfunction

    function automatic int reads(stim_t in, mslot_t w);
        if (w.v == 0 || w.we == 0 || w.rd == 0) return 0;
        return ((in.re1 != 0 && in.rs1 == w.rd) || (in.re2 != 0 && in.rs2 == w.rd)) ? 1 : 0;
    endfunction

    function automatic exp_t predict(mstate_t s, stim_t in);
        exp_t e;
        int haz, frz, memop;
        e = '{default: 0};
        if (in.rst_n == 0) return e;
        haz   = (in.v != 0 && (reads(in, s.ex) + reads(in, s.mem) + reads(in, s.wb)) > 0) ? 1 : 0;
        memop = (s.mem.v != 0 && s.mem.m != 0) ? 1 : 0;
        frz   = (s.err != 0 || (memop != 0 && in.ack == 0)) ? 1 : 0;
        e.adv     = 1 - frz;
        e.pc_we   = (frz == 0 && haz == 0) ? 1 : 0;
        e.ifid_we = e.pc_we;
        e.bubble  = (haz != 0 && frz == 0) ? 1 : 0;
        e.flush   = (e.pc_we != 0 && in.v != 0 && in.br != 0) ? 1 : 0;
        e.req     = (s.err == 0 && memop != 0) ? 1 : 0;
        e.err     = s.err;
        e.stall   = s.stalls;
        return e;
    endfunction

    function automatic mstate_t advance(mstate_t s, stim_t in, int timeout, int smax);
        exp_t   e;
        mslot_t nw;
        if (in.rst_n == 0) return empty_state();
        e = predict(s, in);
        if (e.bubble != 0 && s.stalls < smax) s.stalls++;
        if (s.err == 0 && s.mem.v != 0 && s.mem.m != 0 && in.ack == 0) begin
            s.reqs++;
            if (s.reqs > timeout) s.err = 1;
        end
        if (e.adv != 0) begin
            nw = '{default: 0};
            if (e.pc_we != 0 && in.v != 0) nw = '{v: 1, rd: in.rd, we: in.we, m: in.m};
            s.wb   = s.mem;
            s.mem  = s.ex;
            s.ex   = nw;
            s.reqs = 0;
        end
        return s;
    endfunction

    function automatic stim_t nop(input int ack);
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1;
        s.ack   = ack;
        return s;
    endfunction

    function automatic stim_t instr(input int rd, input int we, input int rs1, input int re1,
                                    input int rs2, input int re2, input int m, input int br,
                                    input int ack);
        stim_t s;
        s = '{rst_n: 1, v: 1, rs1: rs1, rs2: rs2, re1: re1, re2: re2,
              rd: rd, we: we, m: m, br: br, ack: ack};
        return s;
    endfunction

    function automatic stim_t rst_stim();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic apply(input stim_t in);
        reset     = (in.rst_n != 0);
        id_valid  = (in.v != 0);
        id_rs1    = 5'(in.rs1);
        id_rs2    = 5'(in.rs2);
        id_rs1_re = (in.re1 != 0);
        id_rs2_re = (in.re2 != 0);
        id_rd     = 5'(in.rd);
        id_rd_we  = (in.we != 0);
        id_is_mem = (in.m != 0);
        id_br     = (in.br != 0);
        mem_ack   = (in.ack != 0);
    endtask

    // Called at posedge+1: drive, record expectation, then step the model at the edge.
    task automatic run_cycle(input stim_t in);
        exp_pair_t p;
        apply(in);
        p.a = predict(ma, in);
        p.b = predict(mb, in);
        sb.push_back(p);
        @(posedge clk);
        ma = advance(ma, in, TO_A, (1 << SW_A) - 1);
        mb = advance(mb, in, TO_B, (1 << SW_B) - 1);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) run_cycle(rst_stim());
    endtask

    task automatic cmp_set(input string tag, input exp_t act, input exp_t e);
        chk({tag, ".pc_we"},       act.pc_we,   e.pc_we);
        chk({tag, ".ifid_we"},     act.ifid_we, e.ifid_we);
        chk({tag, ".ifid_flush"},  act.flush,   e.flush);
        chk({tag, ".idex_bubble"}, act.bubble,  e.bubble);
        chk({tag, ".pipe_adv"},    act.adv,     e.adv);
        chk({tag, ".mem_req"},     act.req,     e.req);
        chk({tag, ".err"},         act.err,     e.err);
        chk({tag, ".stall_cnt"},   act.stall,   e.stall);
    endtask

    // Monitor: every cycle presents a full set of control outputs.
    always @(negedge clk) begin
        exp_pair_t p;
        exp_t      aa;
        exp_t      ab;
        if (sb.size() > 0) begin
            p = sb.pop_front();
            aa = '{pc_we: int'(pc_we_a), ifid_we: int'(ifid_we_a), flush: int'(flush_a),
                   bubble: int'(bubble_a), adv: int'(adv_a), req: int'(req_a),
                   err: int'(err_a), stall: int'(stall_a)};
            ab = '{pc_we: int'(pc_we_b), ifid_we: int'(ifid_we_b), flush: int'(flush_b),
                   bubble: int'(bubble_b), adv: int'(adv_b), req: int'(req_b),
                   err: int'(err_b), stall: int'(stall_b)};
            cmp_set("dut_a", aa, p.a);
            cmp_set("dut_b", ab, p.b);
        end
    end

    initial begin
        stim_t s;
        ma = empty_state();
        mb = empty_state();
        apply(rst_stim());
        @(posedge clk);
        #1;

        do_reset(3);
        chk("reset_stall_cnt_a", int'(stall_a), 0);
        chk("reset_err_b", int'(err_b), 0);

        // RAW: ADDI x5,x1 then ADD x6,x5,x1 -> three bubbles, issue on the fourth cycle.
        run_cycle(nop(0));
        run_cycle(instr(5, 1, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) run_cycle(instr(6, 1, 5, 1, 1, 1, 0, 0, 0));
        chk("raw_stall_cnt_a", int'(stall_a), 3);

        // x0 writer followed by an x0 reader, SW followed by a read of its rs2: no bubbles.
        run_cycle(instr(0, 1, 1, 1, 0, 0, 0, 0, 1));
        run_cycle(instr(8, 1, 0, 1, 0, 1, 0, 0, 1));
        run_cycle(instr(7, 0, 2, 1, 7, 1, 1, 0, 1));
        run_cycle(instr(9, 1, 7, 1, 0, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++) run_cycle(nop(1));
        chk("exempt_stall_cnt_a", int'(stall_a), 3);

        // Branch without hazard, then a branch reading a just-written register.
        run_cycle(instr(0, 0, 2, 1, 3, 1, 0, 1, 1));
        run_cycle(instr(9, 1, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++) run_cycle(instr(0, 0, 9, 1, 0, 0, 0, 1, 1));
        run_cycle(nop(1));
        chk("branch_stall_cnt_a", int'(stall_a), 6);

        // LW reaches MEM, ack four cycles later; dut_b (TIMEOUT=3) times out first.
        do_reset(1);
        run_cycle(instr(10, 1, 1, 1, 0, 0, 1, 0, 0));
        run_cycle(nop(0));
        for (int i = 0; i < 4; i++) run_cycle(nop(0));
        chk("timeout_err_b", int'(err_b), 1);
        run_cycle(nop(1));
        chk("no_timeout_err_a", int'(err_a), 0);
        for (int i = 0; i < 3; i++) run_cycle(nop(1));
        chk("sticky_err_b", int'(err_b), 1);
        run_cycle(rst_stim());
        chk("reset_clears_err_b", int'(err_b), 0);
        chk("reset_req_b", int'(req_b), 0);
        run_cycle(nop(0));

        // 21 hazard stalls: dut_b's 4-bit counter saturates at 15.
        do_reset(1);
        for (int r = 0; r < 7; r++) begin
            run_cycle(instr(3, 1, 0, 1, 0, 0, 0, 0, 1));
            for (int i = 0; i < 4; i++) run_cycle(instr(4, 0, 3, 1, 0, 0, 0, 0, 1));
        end
        run_cycle(nop(1));
        chk("saturate_stall_cnt_b", int'(stall_b), 15);
        chk("count_stall_cnt_a", int'(stall_a), 21);

        // Randomised traffic with occasional resets to escape ERR.
        for (int i = 0; i < 2500; i++) begin
            s.rst_n = ($urandom_range(0, 99) != 0) ? 1 : 0;
            s.v     = ($urandom_range(0, 3) != 0) ? 1 : 0;
            s.rs1   = int'($urandom_range(0, 7));
            s.rs2   = int'($urandom_range(0, 7));
            s.re1   = int'($urandom_range(0, 1));
            s.re2   = int'($urandom_range(0, 1));
            s.rd    = int'($urandom_range(0, 7));
            s.we    = ($urandom_range(0, 3) != 0) ? 1 : 0;
            s.m     = ($urandom_range(0, 3) == 0) ? 1 : 0;
            s.br    = ($urandom_range(0, 4) == 0) ? 1 : 0;
            s.ack   = ($urandom_range(0, 2) != 0) ? 1 : 0;
            run_cycle(s);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
